npu8_host_seq: RTL and testbench

- Bus-master command sequencer that drives the NPU8 CPU register port (ADR/WR/RD/WDATA/RDATA/INT) from the host side.
- Consumes a valid/ready stream of commands: register write, register read, wait-for-INT, end.
- Issues single-cycle register accesses and returns read data on a result strobe.
- Used in system sims and as the on-chip host that programs, starts and polls npu8_top without a CPU model.

---
 rtl/npu8_host_pkg.sv | 22 ++
 rtl/npu8_host_timer.sv | 27 ++
 rtl/npu8_host_seq.sv | 143 ++++++++++++++
 tb/tb_npu8_host_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu8_host_pkg.sv
// Shared definitions for the NPU8 host sequencer: bus widths, command op codes, state encoding.
package npu8_host_pkg;

    localparam int ADR_W  = 8;
    localparam int DATA_W = 32;

    typedef logic [1:0] op_t;
    typedef logic [2:0] state_t;

    localparam op_t OP_WRITE   = 2'd0;
    localparam op_t OP_READ    = 2'd1;
    localparam op_t OP_WAITINT = 2'd2;
    localparam op_t OP_END     = 2'd3;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_FETCH   = 3'd1;
    localparam state_t S_WRITE   = 3'd2;
    localparam state_t S_READ    = 3'd3;
    localparam state_t S_RWAIT   = 3'd4;
    localparam state_t S_INTWAIT = 3'd5;

endpackage

// File: rtl/npu8_host_timer.sv
// Loadable up-counter with a compare against (limit-1); a limit of zero never completes.
module npu8_host_timer #(
    parameter int TO_W = 16
) (
    input  logic            CLK,
    input  logic            RESET_X,
    input  logic            i_load,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_done
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RESET_X) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counter holds 0 in the first counted cycle, so limit N completes in the Nth cycle.
    assign o_done = (i_limit != '0) && (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/npu8_host_seq.sv
// Host-side command sequencer for the NPU8 register port: turns a valid/ready stream of
// write/read/wait-for-INT/end commands into single-cycle bus accesses.
module npu8_host_seq
    import npu8_host_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int TO_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET_X,
    input  logic              GO,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADR_W-1:0]  CMD_ADR,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic [ADR_W-1:0]  ADR,
    output logic              WR,
    output logic              RD,
    output logic [DATA_W-1:0] WDATA,
    input  logic [DATA_W-1:0] RDATA,
    input  logic              INT,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [ADR_W-1:0]  RD_ADR,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [15:0]       CMD_CNT
);

    localparam logic [TO_W-1:0] RD_LAT_L = TO_W'(RD_LAT);

    state_t             r_state;
    logic [ADR_W-1:0]   r_adr;
    logic [DATA_W-1:0]  r_data;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [ADR_W-1:0]   r_rd_adr;
    logic               r_done;
    logic               r_timeout;
    logic [15:0]        r_cnt;

    state_t             w_next;
    logic               w_hs;
    logic               w_tmr_load;
    logic [TO_W-1:0]    w_tmr_limit;
    logic               w_tmr_done;
    logic               w_sample;
    logic               w_to_hit;

    // One timer serves both wait states; it is held at zero everywhere else.
    assign w_tmr_load  = !((r_state == S_RWAIT) || (r_state == S_INTWAIT));
    assign w_tmr_limit = (r_state == S_RWAIT) ? RD_LAT_L : r_data[TO_W-1:0];

    npu8_host_timer #(.TO_W(TO_W)) u_timer (
        .CLK     (CLK),
        .RESET_X (RESET_X),
        .i_load  (w_tmr_load),
        .i_limit (w_tmr_limit),
        .o_done  (w_tmr_done)
    );

    assign w_hs     = (r_state == S_FETCH) && CMD_VALID;
    assign w_sample = ((r_state == S_READ) && (RD_LAT == 0)) ||
                      ((r_state == S_RWAIT) && w_tmr_done);
    // INT has priority over an expiring timeout in the same cycle.
    assign w_to_hit = (r_state == S_INTWAIT) && !INT && w_tmr_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (GO) w_next = S_FETCH;
            S_FETCH: begin
                if (CMD_VALID) begin
                    case (CMD_OP)
                        OP_WRITE:   w_next = S_WRITE;
                        OP_READ:    w_next = S_READ;
                        OP_WAITINT: w_next = S_INTWAIT;
                        default:    w_next = S_IDLE;
                    endcase
                end
            end
            S_WRITE:   w_next = S_FETCH;
            S_READ:    w_next = (RD_LAT == 0) ? S_FETCH : S_RWAIT;
            S_RWAIT:   if (w_tmr_done) w_next = S_FETCH;
            S_INTWAIT: begin
                if (INT)             w_next = S_FETCH;
                else if (w_tmr_done) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_X) begin
            r_state    <= S_IDLE;
            r_adr      <= '0;
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_adr   <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= w_sample;
            r_done     <= (w_hs && (CMD_OP == OP_END)) || w_to_hit;
            if ((r_state == S_IDLE) && GO) begin
                r_timeout <= 1'b0;
                r_cnt     <= '0;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_hs) begin
                r_adr  <= CMD_ADR;
                r_data <= CMD_DATA;
                r_cnt  <= r_cnt + 16'd1;
            end
            if (w_sample) begin
                r_rd_data <= RDATA;
                r_rd_adr  <= r_adr;
            end
        end
    end

    // Bus is driven only during the strobe cycle; address and data are zero otherwise.
    assign WR        = (r_state == S_WRITE);
    assign RD        = (r_state == S_READ);
    assign ADR       = (WR || RD) ? r_adr : '0;
    assign WDATA     = WR ? r_data : '0;
    assign CMD_READY = (r_state == S_FETCH);
    assign BUSY      = (r_state != S_IDLE);
    assign RD_VALID  = r_rd_valid;
    assign RD_DATA   = r_rd_data;
    assign RD_ADR    = r_rd_adr;
    assign DONE      = r_done;
    assign TIMEOUT   = r_timeout;
    assign CMD_CNT   = r_cnt;

endmodule

// File: tb/tb_npu8_host_seq.sv
// Self-checking bench for npu8_host_seq: three instances (RD_LAT 1, 0, 3) driven by
// randomized command streams, checked against a cycle-stamped event model.
module tb_npu8_host_seq;

    localparam int N = 3;
    localparam logic [1:0] T_WRITE = 2'd0;
    localparam logic [1:0] T_READ  = 2'd1;
    localparam logic [1:0] T_WAIT  = 2'd2;
    localparam logic [1:0] T_END   = 2'd3;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_x     [N];
    logic        go        [N];
    logic        cmd_valid [N];
    logic        cmd_ready [N];
    logic [1:0]  cmd_op    [N];
    logic [7:0]  cmd_adr   [N];
    logic [31:0] cmd_data  [N];
    logic [7:0]  adr       [N];
    logic        wr        [N];
    logic        rd        [N];
    logic [31:0] wdata     [N];
    logic [31:0] rdata     [N];
    logic        intr      [N];
    logic        rd_valid  [N];
    logic [31:0] rd_data   [N];
    logic [7:0]  rd_adr    [N];
    logic        busy      [N];
    logic        done      [N];
    logic        timeout   [N];
    logic [15:0] cmd_cnt   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        npu8_host_seq #(.RD_LAT(lat_of(g)), .TO_W(16)) u_dut (
            .CLK       (CLK),
            .RESET_X   (rst_x[g]),
            .GO        (go[g]),
            .CMD_VALID (cmd_valid[g]),
            .CMD_READY (cmd_ready[g]),
            .CMD_OP    (cmd_op[g]),
            .CMD_ADR   (cmd_adr[g]),
            .CMD_DATA  (cmd_data[g]),
            .ADR       (adr[g]),
            .WR        (wr[g]),
            .RD        (rd[g]),
            .WDATA     (wdata[g]),
            .RDATA     (rdata[g]),
            .INT       (intr[g]),
            .RD_VALID  (rd_valid[g]),
            .RD_DATA   (rd_data[g]),
            .RD_ADR    (rd_adr[g]),
            .BUSY      (busy[g]),
            .DONE      (done[g]),
            .TIMEOUT   (timeout[g]),
            .CMD_CNT   (cmd_cnt[g])
        );
    end

    // Register file model: data is valid only in cycle t+RD_LAT after the RD strobe in cycle t.
    int          cyc = 0;
    int          rd_t [N];
    logic [7:0]  rd_a [N];
    logic [31:0] mem  [256];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int g = 0; g < N; g++) begin
            if (rd[g]) begin
                rd_t[g] <= cyc;
                rd_a[g] <= adr[g];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < N; g++) begin
            rdata[g] = 32'hBAD0_0000 ^ 32'(cyc);
            if ((lat_of(g) == 0) && rd[g])
                rdata[g] = mem[adr[g]];
            else if ((lat_of(g) > 0) && (cyc == rd_t[g] + lat_of(g)))
                rdata[g] = mem[rd_a[g]];
        end
    end

    typedef struct {
        int          cyc;
        logic [7:0]  adr;
        logic [31:0] data;
    } ev_t;

    ev_t         wr_log[$];
    ev_t         rd_log[$];
    ev_t         rv_log[$];
    int          acc_log[$];
    int          done_log[$];
    int          vio;
    logic [1:0]  q_op[$];
    logic [7:0]  q_adr[$];
    logic [31:0] q_data[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] dt);
        q_op.push_back(op);
        q_adr.push_back(a);
        q_data.push_back(dt);
    endtask

    // Pulses GO, feeds the queued commands whenever the DUT is ready, and logs every bus
    // event with its cycle number until DONE has been seen plus a few idle cycles.
    task automatic run(input int d, input int int_delay, input int go_again, output bit ok);
        bit  pend;
        int  int_rise;
        bit  seen_done;
        int  tail;
        int  n;
        ev_t e;
        wr_log.delete(); rd_log.delete(); rv_log.delete();
        acc_log.delete(); done_log.delete();
        vio = 0; pend = 0; int_rise = -1; seen_done = 0; tail = 0; n = 0;
        intr[d] = 1'b0;
        @(negedge CLK); go[d] = 1'b1;
        @(negedge CLK);
        while ((n < 200) && (tail < 6)) begin
            if (pend) begin
                void'(q_op.pop_front()); void'(q_adr.pop_front()); void'(q_data.pop_front());
            end
            e.cyc = cyc;
            if (wr[d]) begin e.adr = adr[d]; e.data = wdata[d]; wr_log.push_back(e); end
            if (rd[d]) begin e.adr = adr[d]; e.data = 32'h0; rd_log.push_back(e); end
            if (rd_valid[d]) begin e.adr = rd_adr[d]; e.data = rd_data[d]; rv_log.push_back(e); end
            if (done[d]) begin done_log.push_back(cyc); seen_done = 1; end
            if (wr[d] && rd[d]) vio++;
            if (!wr[d] && !rd[d] && ((adr[d] != 8'h0) || (wdata[d] != 32'h0))) vio++;
            if (cmd_ready[d] && !busy[d]) vio++;
            if (seen_done) tail++;
            if (q_op.size() > 0) begin
                cmd_valid[d] = 1'b1; cmd_op[d] = q_op[0]; cmd_adr[d] = q_adr[0]; cmd_data[d] = q_data[0];
            end else begin
                cmd_valid[d] = 1'b0; cmd_op[d] = 2'd0; cmd_adr[d] = 8'h0; cmd_data[d] = 32'h0;
            end
            pend = cmd_valid[d] && cmd_ready[d];
            if (pend) begin
                acc_log.push_back(cyc);
                if ((q_op[0] == T_WAIT) && (int_delay >= 0)) int_rise = cyc + int_delay;
            end
            intr[d] = (int_rise >= 0) && (cyc >= int_rise);
            go[d]   = (n == go_again);
            n++;
            @(negedge CLK);
        end
        cmd_valid[d] = 1'b0; go[d] = 1'b0; intr[d] = 1'b0;
        q_op.delete(); q_adr.delete(); q_data.delete();
        ok = seen_done;
    endtask

    task automatic test_reset();
        logic [102:0] obs;
        for (int g = 0; g < N; g++) rst_x[g] = 1'b0;
        repeat (3) @(negedge CLK);
        for (int g = 0; g < N; g++) begin
            obs = {busy[g], cmd_ready[g], wr[g], rd[g], rd_valid[g], done[g], timeout[g],
                   adr[g], wdata[g], rd_data[g], rd_adr[g], cmd_cnt[g]};
            n_checks++;
            if (obs !== '0) begin
                n_fail++; $display("FAIL reset_outputs[%0d]: got %h, expected all zero", g, obs);
            end
        end
        for (int g = 0; g < N; g++) rst_x[g] = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write_end();
        bit ok;
        push_cmd(T_WRITE, 8'h04, 32'h0000_0001);
        push_cmd(T_END, 8'h00, 32'h0);
        run(0, -1, -1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL we_done_seen: got %0d, expected 1", ok); end
        n_checks++; if (wr_log.size() != 1) begin n_fail++; $display("FAIL we_wr_count: got %0d, expected 1", wr_log.size()); end
        if (wr_log.size() >= 1) begin
            n_checks++; if (wr_log[0].adr !== 8'h04) begin n_fail++; $display("FAIL we_adr: got %h, expected 04", wr_log[0].adr); end
            n_checks++; if (wr_log[0].data !== 32'h1) begin n_fail++; $display("FAIL we_wdata: got %h, expected 00000001", wr_log[0].data); end
            if (done_log.size() >= 1) begin
                n_checks++;
                if (done_log[0] != wr_log[0].cyc + 2) begin
                    n_fail++; $display("FAIL we_done_cycle: got %0d, expected %0d", done_log[0], wr_log[0].cyc + 2);
                end
            end
        end
        n_checks++; if (done_log.size() != 1) begin n_fail++; $display("FAIL we_done_pulses: got %0d, expected 1", done_log.size()); end
        n_checks++; if (cmd_cnt[0] !== 16'd2) begin n_fail++; $display("FAIL we_cmd_cnt: got %0d, expected 2", cmd_cnt[0]); end
        n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL we_busy: got %b, expected 0", busy[0]); end
        n_checks++; if (vio != 0) begin n_fail++; $display("FAIL we_bus_rules: got %0d violations, expected 0", vio); end
    endtask

    task automatic test_random_writes();
        bit          ok;
        int          n;
        logic [7:0]  ea[$];
        logic [31:0] ed[$];
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 6);
            ea.delete(); ed.delete();
            for (int i = 0; i < n; i++) begin
                ea.push_back(8'($urandom)); ed.push_back($urandom);
                push_cmd(T_WRITE, ea[i], ed[i]);
            end
            push_cmd(T_END, 8'h0, 32'h0);
            run(0, -1, -1, ok);
            n_checks++; if (wr_log.size() != n) begin n_fail++; $display("FAIL rw_count: got %0d, expected %0d", wr_log.size(), n); end
            for (int i = 0; i < n && i < wr_log.size(); i++) begin
                n_checks++;
                if ((wr_log[i].adr !== ea[i]) || (wr_log[i].data !== ed[i])) begin
                    n_fail++; $display("FAIL rw_access[%0d]: got %h/%h, expected %h/%h", i, wr_log[i].adr, wr_log[i].data, ea[i], ed[i]);
                end
            end
            n_checks++; if (cmd_cnt[0] !== 16'(n + 1)) begin n_fail++; $display("FAIL rw_cmd_cnt: got %0d, expected %0d", cmd_cnt[0], n + 1); end
            n_checks++; if (vio != 0) begin n_fail++; $display("FAIL rw_bus_rules: got %0d violations, expected 0", vio); end
        end
    endtask

    task automatic test_read(input int d);
        bit         ok;
        logic [7:0] ea[2];
        mem[8'h40] = 32'hDEAD_BEEF;
        ea[0] = 8'h40;
        ea[1] = 8'($urandom);
        push_cmd(T_READ, ea[0], 32'h0);
        push_cmd(T_READ, ea[1], 32'h0);
        push_cmd(T_END, 8'h0, 32'h0);
        run(d, -1, -1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rd_done_seen[lat%0d]: got %0d, expected 1", lat_of(d), ok); end
        n_checks++; if (rd_log.size() != 2) begin n_fail++; $display("FAIL rd_strobes[lat%0d]: got %0d, expected 2", lat_of(d), rd_log.size()); end
        n_checks++; if (rv_log.size() != 2) begin n_fail++; $display("FAIL rd_valids[lat%0d]: got %0d, expected 2", lat_of(d), rv_log.size()); end
        for (int i = 0; i < 2 && i < rd_log.size() && i < rv_log.size(); i++) begin
            n_checks++;
            if (rd_log[i].adr !== ea[i]) begin n_fail++; $display("FAIL rd_adr[lat%0d,%0d]: got %h, expected %h", lat_of(d), i, rd_log[i].adr, ea[i]); end
            n_checks++;
            if (rv_log[i].cyc != rd_log[i].cyc + lat_of(d) + 1) begin
                n_fail++; $display("FAIL rd_valid_cycle[lat%0d,%0d]: got %0d, expected %0d", lat_of(d), i, rv_log[i].cyc, rd_log[i].cyc + lat_of(d) + 1);
            end
            n_checks++;
            if ((rv_log[i].data !== mem[ea[i]]) || (rv_log[i].adr !== ea[i])) begin
                n_fail++; $display("FAIL rd_result[lat%0d,%0d]: got %h@%h, expected %h@%h", lat_of(d), i, rv_log[i].data, rv_log[i].adr, mem[ea[i]], ea[i]);
            end
        end
        n_checks++; if (rd_data[d] !== mem[ea[1]]) begin n_fail++; $display("FAIL rd_data_held[lat%0d]: got %h, expected %h", lat_of(d), rd_data[d], mem[ea[1]]); end
        n_checks++; if (cmd_cnt[d] !== 16'd3) begin n_fail++; $display("FAIL rd_cmd_cnt[lat%0d]: got %0d, expected 3", lat_of(d), cmd_cnt[d]); end
        n_checks++; if (vio != 0) begin n_fail++; $display("FAIL rd_bus_rules[lat%0d]: got %0d violations, expected 0", lat_of(d), vio); end
    endtask

    task automatic test_waitint();
        bit ok;
        int tmo[5];
        int dly[5];
        int exp_acc;
        tmo = '{0, 5, 5, 0, 0};
        dly = '{20, 5, 0, 0, 0};
        tmo[3] = $urandom_range(3, 30); dly[3] = $urandom_range(0, tmo[3] - 1);
        dly[4] = $urandom_range(1, 40);
        for (int k = 0; k < 5; k++) begin
            push_cmd(T_WAIT, 8'h0, 32'(tmo[k]));
            push_cmd(T_WRITE, 8'h10, 32'(k));
            push_cmd(T_END, 8'h0, 32'h0);
            run(0, dly[k], -1, ok);
            n_checks++; if (acc_log.size() != 3) begin n_fail++; $display("FAIL wi_accepts[%0d]: got %0d, expected 3", k, acc_log.size()); end
            if (acc_log.size() >= 2) begin
                exp_acc = acc_log[0] + ((dly[k] > 1) ? dly[k] : 1) + 1;
                n_checks++;
                if (acc_log[1] != exp_acc) begin n_fail++; $display("FAIL wi_resume_cycle[%0d]: got %0d, expected %0d", k, acc_log[1], exp_acc); end
            end
            n_checks++; if (timeout[0] !== 1'b0) begin n_fail++; $display("FAIL wi_timeout_flag[%0d]: got %b, expected 0", k, timeout[0]); end
            n_checks++; if (wr_log.size() != 1) begin n_fail++; $display("FAIL wi_write_after[%0d]: got %0d, expected 1", k, wr_log.size()); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int tmo;
        for (int k = 0; k < 2; k++) begin
            tmo = (k == 0) ? 5 : $urandom_range(1, 12);
            push_cmd(T_WAIT, 8'h0, 32'(tmo));
            push_cmd(T_WRITE, 8'h22, 32'h1234);
            push_cmd(T_END, 8'h0, 32'h0);
            run(0, -1, -1, ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_done_seen[%0d]: got %0d, expected 1", tmo, ok); end
            if ((done_log.size() >= 1) && (acc_log.size() >= 1)) begin
                n_checks++;
                if (done_log[0] != acc_log[0] + tmo + 1) begin
                    n_fail++; $display("FAIL to_done_cycle[%0d]: got %0d, expected %0d", tmo, done_log[0], acc_log[0] + tmo + 1);
                end
            end
            n_checks++; if (timeout[0] !== 1'b1) begin n_fail++; $display("FAIL to_flag_set[%0d]: got %b, expected 1", tmo, timeout[0]); end
            n_checks++; if (acc_log.size() != 1) begin n_fail++; $display("FAIL to_not_consumed[%0d]: got %0d accepts, expected 1", tmo, acc_log.size()); end
            n_checks++; if (cmd_cnt[0] !== 16'd1) begin n_fail++; $display("FAIL to_cmd_cnt[%0d]: got %0d, expected 1", tmo, cmd_cnt[0]); end
            n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL to_no_write[%0d]: got %0d, expected 0", tmo, wr_log.size()); end
            push_cmd(T_END, 8'h0, 32'h0);
            run(0, -1, -1, ok);
            n_checks++; if (timeout[0] !== 1'b0) begin n_fail++; $display("FAIL to_flag_cleared[%0d]: got %b, expected 0", tmo, timeout[0]); end
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        logic [7:0] ea[3];
        for (int i = 0; i < 3; i++) begin
            ea[i] = 8'($urandom);
            push_cmd(T_WRITE, ea[i], $urandom);
        end
        push_cmd(T_END, 8'h0, 32'h0);
        run(0, -1, 2, ok);
        n_checks++; if (wr_log.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 3", wr_log.size()); end
        for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].adr !== ea[i]) begin n_fail++; $display("FAIL b2b_adr[%0d]: got %h, expected %h", i, wr_log[i].adr, ea[i]); end
            if (i > 0) begin
                n_checks++;
                if (wr_log[i].cyc != wr_log[i-1].cyc + 2) begin
                    n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d, expected %0d", i, wr_log[i].cyc, wr_log[i-1].cyc + 2);
                end
            end
        end
        n_checks++; if (cmd_cnt[0] !== 16'd4) begin n_fail++; $display("FAIL b2b_cmd_cnt: got %0d, expected 4", cmd_cnt[0]); end
        n_checks++; if (done_log.size() != 1) begin n_fail++; $display("FAIL b2b_done: got %0d, expected 1", done_log.size()); end
        n_checks++; if (vio != 0) begin n_fail++; $display("FAIL b2b_bus_rules: got %0d violations, expected 0", vio); end
    endtask

    task automatic test_reset_mid_write();
        bit found = 0;
        @(negedge CLK); go[0] = 1'b1;
        @(negedge CLK); go[0] = 1'b0;
        cmd_valid[0] = 1'b1; cmd_op[0] = T_WRITE; cmd_adr[0] = 8'h04; cmd_data[0] = 32'h1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (wr[0]) found = 1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmw_wr_seen: got %0d, expected 1", found); end
        rst_x[0] = 1'b0; cmd_valid[0] = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({wr[0], busy[0], cmd_ready[0], cmd_cnt[0]} !== 19'h0) begin
            n_fail++; $display("FAIL rmw_abort: got wr=%b busy=%b ready=%b cnt=%0d, expected all 0", wr[0], busy[0], cmd_ready[0], cmd_cnt[0]);
        end
        @(negedge CLK);
        n_checks++; if (wr[0] !== 1'b0) begin n_fail++; $display("FAIL rmw_no_strobe: got %b, expected 0", wr[0]); end
        rst_x[0] = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            rst_x[g] = 1'b0; go[g] = 1'b0; cmd_valid[g] = 1'b0; cmd_op[g] = 2'd0;
            cmd_adr[g] = 8'h0; cmd_data[g] = 32'h0; intr[g] = 1'b0;
        end
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_write_end();
        test_random_writes();
        for (int d = 0; d < N; d++) test_read(d);
        test_waitint();
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
